// File: rtl/pipelined_adder.sv
// ============================================================================
// pipelined_adder
//
// Purpose
//    Pipelined WIDTH-bit adder/subtractor for the matrix datapath. The carry
//    chain is cut into STAGES registered slices of CHUNK = WIDTH/STAGES bits.
//    Each slice adds one chunk of the operands plus the carry registered by
//    the slice before it. One operand pair is accepted per cycle under a
//    valid/ready handshake with full backpressure. Results appear STAGES
//    cycles after acceptance.
//
// Parameters
//    WIDTH      operand/result width in bits (must be a multiple of STAGES)
//    STAGES     number of pipeline slices, 1 <= STAGES <= WIDTH
//
// Ports
//    clk        rising-edge clock, sole clock domain
//    reset      synchronous, active-high reset; discards everything in flight
//    in_valid   operand pair (a, b, carryin, sub) valid this cycle
//    in_ready   block accepts input this cycle (pipeline can advance)
//    a, b       operands
//    carryin    carry into bit 0 in add mode, ignored in subtract mode
//    sub        0: a + b + carryin, 1: a - b computed as a + ~b + 1
//    out_valid  sum/carryout/overflow hold a valid result
//    out_ready  downstream accepts the result
//    sum        result modulo 2^WIDTH
//    carryout   carry out of the MSB (subtract: 1 means no borrow)
//    overflow   two's-complement overflow (carry into MSB xor carry out)
// ============================================================================
module pipelined_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow
);

   localparam int CHUNK = WIDTH / STAGES;

   // The carry chain only splits cleanly when every slice has the same width.
   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : gParamCheck
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   logic             adv;
   logic [WIDTH-1:0] bEff;
   logic             c0;

   // The whole pipe moves as one: it advances whenever the output slot is
   // empty or being consumed, otherwise every slice holds (full stall).
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Subtraction is folded into the adder as a + ~b + 1 so that every slice
   // is a plain chunk adder regardless of mode.
   assign bEff = sub ? ~b : b;
   assign c0   = sub ? 1'b1 : carryin;

   for (genvar k = 0; k < STAGES; k++) begin : gStage
      // REM  = operand bits still waiting to be added after this slice
      // DONE = result bits completed once this slice has registered
      localparam int REM  = WIDTH - (k + 1) * CHUNK;
      localparam int DONE = (k + 1) * CHUNK;

      logic [CHUNK-1:0] aChunk;
      logic [CHUNK-1:0] bChunk;
      logic             cIn;
      logic             validIn;
      logic [CHUNK:0]   chunkSum;
      logic [DONE-1:0]  sumD;
      logic [DONE-1:0]  sumQ;
      logic             carryD;
      logic             carryQ;
      logic             validQ;

      // Slice 0 takes its chunk straight from the ports; later slices take
      // the lowest remaining bits of the operands delayed by the slice before
      // and append their chunk above the already-finished low result bits.
      if (k == 0) begin : gSrc
         assign aChunk  = a[CHUNK-1:0];
         assign bChunk  = bEff[CHUNK-1:0];
         assign cIn     = c0;
         assign validIn = in_valid;
         assign sumD    = chunkSum[CHUNK-1:0];
      end else begin : gSrc
         assign aChunk  = gStage[k-1].gRem.aRemQ[CHUNK-1:0];
         assign bChunk  = gStage[k-1].gRem.bRemQ[CHUNK-1:0];
         assign cIn     = gStage[k-1].carryQ;
         assign validIn = gStage[k-1].validQ;
         assign sumD    = {chunkSum[CHUNK-1:0], gStage[k-1].sumQ};
      end

      assign chunkSum = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, cIn};
      assign carryD   = chunkSum[CHUNK];

      // Valid bits always shift on advance so bubbles travel with the data.
      // Data registers only load for real transactions, which keeps the
      // output registers at their last value while out_valid is low.
      always_ff @(posedge clk) begin
         if (reset) begin
            validQ <= 1'b0;
            sumQ   <= '0;
            carryQ <= 1'b0;
         end else if (adv) begin
            validQ <= validIn;
            if (validIn) begin
               sumQ   <= sumD;
               carryQ <= carryD;
            end
         end
      end

      // Operand bits not yet consumed ride along, shifted down so the next
      // slice always finds its chunk at the bottom.
      if (REM > 0) begin : gRem
         logic [REM-1:0] aRemD;
         logic [REM-1:0] bRemD;
         logic [REM-1:0] aRemQ;
         logic [REM-1:0] bRemQ;

         if (k == 0) begin : gRemSrc
            assign aRemD = a[WIDTH-1:CHUNK];
            assign bRemD = bEff[WIDTH-1:CHUNK];
         end else begin : gRemSrc
            assign aRemD = gStage[k-1].gRem.aRemQ[REM+CHUNK-1:CHUNK];
            assign bRemD = gStage[k-1].gRem.bRemQ[REM+CHUNK-1:CHUNK];
         end

         // Delayed operand bits move only alongside a real transaction.
         always_ff @(posedge clk) begin
            if (reset) begin
               aRemQ <= '0;
               bRemQ <= '0;
            end else if (adv && validIn) begin
               aRemQ <= aRemD;
               bRemQ <= bRemD;
            end
         end
      end

      // The last slice owns the result registers. The carry into the MSB is
      // recovered from the MSB sum bit (a ^ b ^ cin) so overflow can be
      // registered together with the final carry.
      if (k == STAGES - 1) begin : gLast
         logic msbCarryIn;
         logic overflowD;
         logic overflowQ;

         assign msbCarryIn = aChunk[CHUNK-1] ^ bChunk[CHUNK-1] ^ chunkSum[CHUNK-1];
         assign overflowD  = msbCarryIn ^ chunkSum[CHUNK];

         // Overflow follows the same load rule as the sum and carry.
         always_ff @(posedge clk) begin
            if (reset) begin
               overflowQ <= 1'b0;
            end else if (adv && validIn) begin
               overflowQ <= overflowD;
            end
         end

         assign out_valid = validQ;
         assign sum       = sumQ;
         assign carryout  = carryQ;
         assign overflow  = overflowQ;
      end
   end

endmodule
